// File: rtl/dvi_pkg.sv
// Shared TMDS definitions: control tokens, alignment FSM states, token decode helpers.
package dvi_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_e;

  // One decoded pixel-clock word as presented on the outputs.
  typedef struct packed {
    logic       de;
    logic       c1;
    logic       c0;
    logic [7:0] d;
  } tmds_dec_t;

  // True when the word is one of the four control tokens.
  function automatic logic is_ctrl_token(input logic [9:0] w);
    logic hit;
    hit = 1'b0;
    case (w)
      CTRL_TOKEN_00, CTRL_TOKEN_01, CTRL_TOKEN_10, CTRL_TOKEN_11: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Maps a control token to {C1,C0}; non-tokens map to 00.
  function automatic logic [1:0] ctrl_to_c(input logic [9:0] w);
    logic [1:0] c;
    c = 2'b00;
    case (w)
      CTRL_TOKEN_01: c = 2'b01;
      CTRL_TOKEN_10: c = 2'b10;
      CTRL_TOKEN_11: c = 2'b11;
      default:       c = 2'b00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvi_align_fsm.sv
// Word-boundary hunt: counts control-token runs, issues bitslip on timeout, tracks lock.
module dvi_align_fsm
  import dvi_pkg::*;
#(
  parameter int unsigned LOCK_CNT       = 16,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned LOSS_TIMEOUT   = 4096,
  parameter int unsigned SLIP_WAIT      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_seen,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slip_count
);

  localparam int unsigned RUN_W  = $clog2(LOCK_CNT) + 1;
  localparam int unsigned TMR_W  = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT) + 1;
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT) + 1;

  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CNT);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [3:0]        SLIP_MAX  = 4'd9;

  align_state_e      state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        slip_cnt_q, slip_cnt_d;
  logic              bitslip_q, bitslip_d;
  logic              locked_q, locked_d;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SEARCH;
      run_q      <= '0;
      timer_q    <= '0;
      loss_q     <= '0;
      wait_q     <= '0;
      slip_cnt_q <= '0;
      bitslip_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      timer_q    <= timer_d;
      loss_q     <= loss_d;
      wait_q     <= wait_d;
      slip_cnt_q <= slip_cnt_d;
      bitslip_q  <= bitslip_d;
      locked_q   <= locked_d;
    end
  end

  // Next state; bitslip is registered so it is high exactly while in SLIP.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    timer_d    = timer_q;
    loss_d     = loss_q;
    wait_d     = wait_q;
    slip_cnt_d = slip_cnt_q;
    bitslip_d  = 1'b0;
    locked_d   = locked_q;
    case (state_q)
      ST_SEARCH: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + TMR_W'(1);
        if (ctrl_seen) run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);
        else           run_d = '0;
        // Reaching lock wins over a simultaneous search timeout.
        if (run_d == RUN_LOCK) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
          loss_d   = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d    = ST_SLIP;
          bitslip_d  = 1'b1;
          slip_cnt_d = (slip_cnt_q >= SLIP_MAX) ? 4'd0 : slip_cnt_q + 4'd1;
        end
      end
      ST_SLIP: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end
      ST_WAIT: begin
        // Deserialiser output is unsettled here, so tokens are ignored.
        if (wait_q == WAIT_LAST) begin
          state_d = ST_SEARCH;
          timer_d = '0;
          run_d   = '0;
        end else begin
          wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (ctrl_seen) begin
          loss_d = '0;
        end else if (loss_q == LOSS_LAST) begin
          state_d    = ST_SEARCH;
          locked_d   = 1'b0;
          timer_d    = '0;
          run_d      = '0;
          loss_d     = '0;
          slip_cnt_d = '0;
        end else begin
          loss_d = (loss_q == '1) ? loss_q : loss_q + LOSS_W'(1);
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  assign bitslip    = bitslip_q;
  assign locked     = locked_q;
  assign slip_count = slip_cnt_q;

endmodule

// File: rtl/dvi_decoder.sv
// TMDS receive channel: registers the deserialised word, decodes data/control, aligns words.
module dvi_decoder
  import dvi_pkg::*;
#(
  parameter int unsigned LOCK_CNT       = 16,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned LOSS_TIMEOUT   = 4096,
  parameter int unsigned SLIP_WAIT      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] q_in,
  output logic [7:0] D,
  output logic       C0,
  output logic       C1,
  output logic       DE,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slip_count
);

  logic [9:0] word_q;
  tmds_dec_t  out_q, out_d;
  logic       ctrl_c;
  logic [7:0] unmask_c;
  logic [7:0] data_c;

  // Input word register; all detection works on this copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) word_q <= '0;
    else        word_q <= q_in;
  end

  assign ctrl_c = is_ctrl_token(word_q);

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    unmask_c  = word_q[9] ? ~word_q[7:0] : word_q[7:0];
    data_c    = '0;
    data_c[0] = unmask_c[0];
    for (int i = 1; i < 8; i++) begin
      data_c[i] = word_q[8] ? (unmask_c[i] ^ unmask_c[i-1])
                            : ~(unmask_c[i] ^ unmask_c[i-1]);
    end
  end

  // Output selection: control bits hold across data; data gated until aligned.
  always_comb begin
    out_d = out_q;
    if (ctrl_c) begin
      out_d.de         = 1'b0;
      out_d.d          = '0;
      {out_d.c1, out_d.c0} = ctrl_to_c(word_q);
    end else begin
      out_d.de = locked;
      out_d.d  = locked ? data_c : 8'h00;
    end
  end

  // Decoded output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign D  = out_q.d;
  assign C0 = out_q.c0;
  assign C1 = out_q.c1;
  assign DE = out_q.de;

  dvi_align_fsm #(
    .LOCK_CNT       (LOCK_CNT),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT),
    .SLIP_WAIT      (SLIP_WAIT)
  ) u_align (
    .clk        (clk),
    .reset      (reset),
    .ctrl_seen  (ctrl_c),
    .bitslip    (bitslip),
    .locked     (locked),
    .slip_count (slip_count)
  );

endmodule

// File: tb/tb_dvi_decoder.sv
// Bench for dvi_decoder: reference TMDS encoder, emulated bit-rotating deserialiser.
`timescale 1ns/1ps
module tb_dvi_decoder;

  localparam int unsigned LOCK_CNT       = 16;
  localparam int unsigned SEARCH_TIMEOUT = 4096;
  localparam int unsigned LOSS_TIMEOUT   = 4096;
  localparam int unsigned SLIP_WAIT      = 4;
  localparam int          SLIP_PERIOD    = int'(SEARCH_TIMEOUT + SLIP_WAIT + 1);

  logic       clk;
  logic       reset;
  logic [9:0] q_in;
  logic [7:0] D;
  logic       C0, C1, DE, bitslip, locked;
  logic [3:0] slip_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  dvi_decoder #(
    .LOCK_CNT       (LOCK_CNT),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT),
    .SLIP_WAIT      (SLIP_WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .D          (D),
    .C0         (C0),
    .C1         (C1),
    .DE         (DE),
    .bitslip    (bitslip),
    .locked     (locked),
    .slip_count (slip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control token whose {C1,C0} equals c.
  function automatic logic [9:0] tok(input int unsigned c);
    case (c)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Reference TMDS data encoder with a forced DC-balance polarity.
  function automatic logic [9:0] tmds_encode(input logic [7:0] d, input logic inv);
    logic [8:0] qm;
    int n1;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  // Word seen by a deserialiser whose boundary sits off bits into a repeating word.
  function automatic logic [9:0] rot_word(input logic [9:0] t, input int unsigned off);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = t[(i + off) % 10];
    return w;
  endfunction

  task automatic drive(input logic [9:0] w);
    q_in = w;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    q_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    q_in  = tok(0);
    #2 reset = 1'b0;
    #1;
    checks++; if (D !== 8'h00) begin failures++; $display("FAIL reset_D got=%h exp=00", D); end
    checks++; if ({C1, C0, DE} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {C1, C0, DE}); end
    checks++; if (bitslip !== 1'b0) begin failures++; $display("FAIL reset_bitslip got=%b exp=0", bitslip); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (slip_count !== 4'd0) begin failures++; $display("FAIL reset_slip_count got=%0d exp=0", slip_count); end
    @(posedge clk);
    #1;
    checks++;
    if ({D, C1, C0, DE, bitslip, locked, slip_count} !== 17'h0) begin
      failures++;
      $display("FAIL reset_held got=%h exp=0", {D, C1, C0, DE, bitslip, locked, slip_count});
    end
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_aligned_lock();
    for (int n = 1; n <= 20; n++) begin
      drive(tok(0));
      checks++;
      if (locked !== 1'(n >= int'(LOCK_CNT) + 1)) begin
        failures++; $display("FAIL lock_locked word=%0d got=%b exp=%b", n, locked, n >= int'(LOCK_CNT) + 1);
      end
      checks++;
      if (bitslip !== 1'b0) begin failures++; $display("FAIL lock_bitslip word=%0d got=%b exp=0", n, bitslip); end
      if (n >= int'(LOCK_CNT) + 2) begin
        checks++;
        if ({DE, C1, C0, D} !== 11'h000) begin
          failures++; $display("FAIL lock_outputs word=%0d got=%h exp=000", n, {DE, C1, C0, D});
        end
      end
    end
  endtask

  // Shared shape for the locked-stream tests: output reflects the previous word.
  task automatic run_stream(input string name, input logic [9:0] words[$], input logic [10:0] exps[$]);
    for (int j = 0; j < words.size(); j++) begin
      drive(words[j]);
      if (j > 0) begin
        checks++;
        if ({DE, C1, C0, D} !== exps[j-1]) begin
          failures++; $display("FAIL %s idx=%0d got=%h exp=%h", name, j - 1, {DE, C1, C0, D}, exps[j-1]);
        end
      end
    end
  endtask

  task automatic test_data_decode();
    logic [9:0]  words[$];
    logic [10:0] exps[$];
    logic [7:0]  fixed[4] = '{8'h00, 8'hFF, 8'h55, 8'hA3};
    logic [7:0]  b;
    logic        inv;
    words.push_back(tok(3)); exps.push_back({1'b0, 2'b11, 8'h00});
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 2; p++) begin
        words.push_back(tmds_encode(fixed[k], 1'(p)));
        exps.push_back({1'b1, 2'b11, fixed[k]});
      end
    end
    for (int k = 0; k < 8; k++) begin
      b   = 8'($urandom);
      inv = 1'($urandom_range(0, 1));
      words.push_back(tmds_encode(b, inv));
      exps.push_back({1'b1, 2'b11, b});
    end
    words.push_back(tok(1)); exps.push_back({1'b0, 2'b01, 8'h00});
    words.push_back(tok(1));
    run_stream("data_decode", words, exps);
  endtask

  task automatic test_ctrl_map();
    logic [9:0]  words[$];
    logic [10:0] exps[$];
    logic [7:0]  b;
    for (int c = 0; c < 4; c++) begin
      words.push_back(tok(c)); exps.push_back({1'b0, 2'(c), 8'h00});
      b = 8'($urandom);
      words.push_back(tmds_encode(b, 1'($urandom_range(0, 1))));
      exps.push_back({1'b1, 2'(c), b});
    end
    words.push_back(tok(0));
    run_stream("ctrl_map", words, exps);
  endtask

  task automatic test_misaligned();
    int unsigned off      = 3;
    int          slips    = 0;
    int          last     = 0;
    int          lock_cyc = -1;
    int          exp_cyc;
    logic        prev_bs  = 1'b0;
    logic        done     = 1'b0;
    apply_reset();
    for (int k = 0; k < 8 * SLIP_PERIOD + 100 && !done; k++) begin
      drive(rot_word(tok(0), off));
      if (bitslip === 1'b1) begin
        exp_cyc = (slips == 0) ? int'(SEARCH_TIMEOUT) : last + SLIP_PERIOD;
        slips++;
        checks++;
        if (prev_bs !== 1'b0) begin failures++; $display("FAIL slip_consecutive cyc=%0d got=1 exp=0", cyc); end
        checks++;
        if (cyc != exp_cyc) begin failures++; $display("FAIL slip_timing slip=%0d got=%0d exp=%0d", slips, cyc, exp_cyc); end
        checks++;
        if (slip_count !== 4'(slips % 10)) begin
          failures++; $display("FAIL slip_count slip=%0d got=%0d exp=%0d", slips, slip_count, slips % 10);
        end
        last = cyc;
        off  = (off + 1) % 10;
      end
      prev_bs = bitslip;
      if (locked === 1'b1) begin
        lock_cyc = cyc;
        done     = 1'b1;
      end
    end
    checks++; if (lock_cyc < 0) begin failures++; $display("FAIL misalign_lock_timeout got=unlocked exp=locked"); end
    checks++; if (slips != 7) begin failures++; $display("FAIL misalign_slips got=%0d exp=7", slips); end
    checks++; if (slip_count !== 4'd7) begin failures++; $display("FAIL misalign_slip_count got=%0d exp=7", slip_count); end
    checks++;
    if (lock_cyc != last + int'(SLIP_WAIT) + 1 + int'(LOCK_CNT)) begin
      failures++; $display("FAIL misalign_lock_cyc got=%0d exp=%0d", lock_cyc, last + int'(SLIP_WAIT) + 1 + int'(LOCK_CNT));
    end
  endtask

  task automatic test_loss_of_lock();
    logic [7:0] prev_b = 8'h00;
    logic [7:0] b;
    drive(tok(0));
    for (int m = 1; m <= int'(LOSS_TIMEOUT) + 2; m++) begin
      b = 8'($urandom);
      drive(tmds_encode(b, 1'($urandom_range(0, 1))));
      checks++;
      if (locked !== 1'(m <= int'(LOSS_TIMEOUT))) begin
        failures++; $display("FAIL loss_locked word=%0d got=%b exp=%b", m, locked, m <= int'(LOSS_TIMEOUT));
      end
      checks++;
      if (bitslip !== 1'b0) begin failures++; $display("FAIL loss_bitslip word=%0d got=%b exp=0", m, bitslip); end
      if (m >= 2 && m <= int'(LOSS_TIMEOUT) + 1) begin
        checks++;
        if ({DE, D} !== {1'b1, prev_b}) begin
          failures++; $display("FAIL loss_data word=%0d got=%h exp=%h", m - 1, {DE, D}, {1'b1, prev_b});
        end
      end
      if (m >= int'(LOSS_TIMEOUT) + 1) begin
        checks++;
        if (slip_count !== 4'd0) begin failures++; $display("FAIL loss_slip_count word=%0d got=%0d exp=0", m, slip_count); end
      end
      if (m == int'(LOSS_TIMEOUT) + 2) begin
        checks++;
        if ({DE, D} !== 9'h000) begin failures++; $display("FAIL loss_gating got=%h exp=000", {DE, D}); end
      end
      prev_b = b;
    end
    for (int t = 1; t <= int'(LOCK_CNT) + 1; t++) begin
      drive(tok(0));
      checks++;
      if (locked !== 1'(t >= int'(LOCK_CNT) + 1)) begin
        failures++; $display("FAIL relock word=%0d got=%b exp=%b", t, locked, t >= int'(LOCK_CNT) + 1);
      end
    end
  endtask

  task automatic test_reset_mid_slip();
    logic seen     = 1'b0;
    int   slip_cyc = -1;
    apply_reset();
    for (int k = 0; k < int'(SEARCH_TIMEOUT) + 20 && !seen; k++) begin
      drive(tmds_encode(8'($urandom), 1'($urandom_range(0, 1))));
      if (bitslip === 1'b1) begin
        seen     = 1'b1;
        slip_cyc = cyc;
      end
    end
    checks++;
    if (slip_cyc != int'(SEARCH_TIMEOUT)) begin
      failures++; $display("FAIL midslip_slip_cyc got=%0d exp=%0d", slip_cyc, SEARCH_TIMEOUT);
    end
    #1 reset = 1'b0;
    #1;
    checks++; if (bitslip !== 1'b0) begin failures++; $display("FAIL midslip_bitslip got=%b exp=0", bitslip); end
    checks++; if (slip_count !== 4'd0) begin failures++; $display("FAIL midslip_slip_count got=%0d exp=0", slip_count); end
    checks++; if ({D, C1, C0, DE, locked} !== 12'h000) begin
      failures++; $display("FAIL midslip_outputs got=%h exp=000", {D, C1, C0, DE, locked});
    end
    for (int k = 0; k < 3; k++) begin
      drive(tok(3));
      checks++;
      if ({D, C1, C0, DE, bitslip, locked, slip_count} !== 17'h0) begin
        failures++; $display("FAIL midslip_held edge=%0d got=%h exp=0", k, {D, C1, C0, DE, bitslip, locked, slip_count});
      end
    end
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    test_reset();
    test_aligned_lock();
    test_data_decode();
    test_ctrl_map();
    test_misaligned();
    test_loss_of_lock();
    test_reset_mid_slip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvi_decoder.md
Name: dvi_decoder

Overview:
- Receive-side TMDS channel decoder. Turns one deserialised 10-bit TMDS word per pixel clock back into 8-bit pixel data, C0/C1 control bits and DE.
- Includes a word-alignment state machine that hunts for the correct word boundary by pulsing bitslip to the upstream deserialiser until control tokens are seen reliably.
- One instance per TMDS channel, between the serdes/bitslip front end and the video timing logic.

Parameters:
- LOCK_CNT, 16: consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 4096: words allowed in SEARCH without reaching lock before a slip is issued.
- LOSS_TIMEOUT, 4096: words allowed in LOCKED without any control token before lock is dropped.
- SLIP_WAIT, 4: settle cycles after each bitslip pulse.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- q_in  in  10  parallel TMDS word from the deserialiser; bit 0 is first on the wire.
- D  out  8  decoded pixel data.
- C0  out  1  decoded control bit 0.
- C1  out  1  decoded control bit 1.
- DE  out  1  data enable.
- bitslip  out  1  one-cycle request to the deserialiser to shift the word boundary by one bit.
- locked  out  1  word alignment achieved.
- slip_count  out  4  number of slips issued since the last search start, modulo 10.

Behaviour:
- Reset (reset=0, asynchronous): all registers cleared.
  - D=0, C0=0, C1=0, DE=0, bitslip=0, locked=0, slip_count=0.
  - FSM in SEARCH, all counters 0.
- Pipeline:
  - q_in is registered into q_r on every edge.
  - Control-token detect and decode operate on q_r.
  - D/C0/C1/DE are registered, so output latency is 2 cycles from q_in.
- Control tokens (exact 10-bit match):
  - 1101010100 -> {C1,C0}=00
  - 0010101011 -> {C1,C0}=01
  - 0101010100 -> {C1,C0}=10
  - 1010101011 -> {C1,C0}=11
- On a control token: DE=0, C1/C0 per the map above, D=0.
- On any other word (data token): DE=1, and C0/C1 hold their last values. Decode:
  - d = q_r[9] ? ~q_r[7:0] : q_r[7:0]
  - D[0] = d[0]
  - for i = 1..7: D[i] = q_r[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])
- Output gating while locked=0: DE forced to 0 and D forced to 0; C0/C1 still decode.
- FSM states: SEARCH, SLIP, WAIT, LOCKED. The FSM evaluates the control-detect of q_r each cycle.
- SEARCH:
  - Every cycle: timer+1. On a control token run+1, otherwise run=0.
  - run reaching LOCK_CNT -> LOCKED, locked=1 on the next edge. This check takes priority if the timeout hits in the same cycle.
  - Otherwise timer reaching SEARCH_TIMEOUT-1 -> SLIP.
- SLIP:
  - Lasts one cycle. bitslip=1 for exactly that cycle.
  - slip_count increments, wrapping 9 -> 0.
  - Go to WAIT.
- WAIT:
  - Lasts SLIP_WAIT cycles; tokens are ignored.
  - Then return to SEARCH with timer=0 and run=0.
- LOCKED:
  - A control token clears the loss timer; any other word increments it.
  - Loss timer reaching LOSS_TIMEOUT-1 -> SEARCH with locked=0, and timer, run and slip_count cleared.
- bitslip is asserted only in SLIP, never in two consecutive cycles.
- Counter widths are $clog2 of the relevant parameter plus 1. Counters saturate; they never wrap silently.
- Reset asserted mid-operation: immediate return to the reset state, including dropping bitslip within the same cycle.

Decomposition:
- Shared package dvi_pkg holds:
  - the four control-token constants, shared with the encoder;
  - the FSM state enum;
  - the token-to-{C1,C0} mapping function.
- One natural sub-module: dvi_align_fsm (the SEARCH/SLIP/WAIT/LOCKED logic plus its counters), taking ctrl_seen and producing bitslip, locked and slip_count.
- Decode datapath stays in the top level.

Test Plan:
- Aligned blanking lock:
  - Stimulus: feed 20 consecutive 1101010100 after reset.
  - Required response: locked rises at word 16 + latency, bitslip never asserted, and once locked DE=0, C1C0=00.
- Data decode round-trip:
  - Stimulus: once locked, feed encoder outputs for D=0x00, 0xFF, 0x55, 0xA3, including both DC-balance polarities.
  - Required response: D reproduces each value 2 cycles later with DE=1, and C0/C1 hold their previous values.
- Misaligned stream:
  - Stimulus: send 1101010100 repeatedly, rotated by 3 bits.
  - Required response: a bitslip pulse every SEARCH_TIMEOUT+SLIP_WAIT+1 cycles; after the bench applies 7 slips (3+7=10 bits, word-aligned) locked=1 and slip_count=7.
- Loss of lock:
  - Stimulus: while locked, feed only data tokens for LOSS_TIMEOUT words.
  - Required response: locked falls, DE forced to 0, FSM returns to SEARCH with slip_count=0.
- Control mapping:
  - Stimulus: while locked, cycle through all four control tokens.
  - Required response: C1C0 = 00, 01, 10, 11 respectively, with DE=0.
- Reset mid-slip:
  - Stimulus: assert reset during the bitslip=1 cycle.
  - Required response: bitslip drops immediately, and all outputs equal their reset values until reset is released.
